// File: rtl/cdc_pkg.sv
// Shared types and defaults for the slow-domain pulse receiver.
// Holds the receiver FSM encoding and the high-length counter width.
package cdc_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        QUAL,
        HIGH
    } cdc_state_t;

    localparam int HLEN_W       = 8;
    localparam int CNT_W_DEF    = 4;
    localparam int MIN_HIGH_DEF = 2;
    localparam int MAX_HIGH_DEF = 8;

endpackage

// File: rtl/cdc_evt_cnt.sv
// Saturating up/down pending-event counter.
// Pops on an empty counter are ignored; pushes on a full one strobe ovf.
module cdc_evt_cnt
    import cdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_nxt;
    logic             pop;
    logic             nz_q;

    assign full  = (count == CNT_MAX);
    assign empty = ~nz_q;

    always_comb begin
        pop     = dec & nz_q;
        cnt_nxt = count;
        ovf     = 1'b0;
        unique case ({inc, pop})
            2'b10: begin
                if (full) ovf = 1'b1;
                else      cnt_nxt = count + 1'b1;
            end
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            nz_q  <= 1'b0;
        end else begin
            count <= cnt_nxt;
            nz_q  <= |cnt_nxt;
        end
    end

endmodule

// File: rtl/cdc_slow_pulse_recv.sv
// Turns a synchronized stretched level into queued single-cycle events.
// Define CDC_PULSE_GLITCH_FILTER_EN to reject highs shorter than MIN_HIGH.
module cdc_slow_pulse_recv
    import cdc_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MIN_HIGH = MIN_HIGH_DEF,
    parameter int MAX_HIGH = MAX_HIGH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_lvl,
    input  logic             err_clr,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pending,
    output logic             overrun,
    output logic             stuck_err
);

    if (MAX_HIGH < 2 || MAX_HIGH > 255) begin : g_bad_max
        $error("MAX_HIGH out of range");
    end
    if (MIN_HIGH < 1 || MIN_HIGH >= MAX_HIGH) begin : g_bad_min
        $error("MIN_HIGH out of range");
    end

    localparam logic [HLEN_W-1:0] MAX_L = HLEN_W'(MAX_HIGH);
`ifdef CDC_PULSE_GLITCH_FILTER_EN
    localparam logic [HLEN_W-1:0] MIN_L = HLEN_W'(MIN_HIGH);
`endif

    cdc_state_t        st_q, st_d;
    logic [HLEN_W-1:0] hlen_q, hlen_d, hlen_inc;
    logic              accept, stuck_set;
    logic              cnt_full, cnt_empty, cnt_ovf;

    assign hlen_inc = (hlen_q == '1) ? hlen_q : hlen_q + 1'b1;

    always_comb begin
        st_d      = st_q;
        hlen_d    = hlen_q;
        accept    = 1'b0;
        stuck_set = 1'b0;
        unique case (st_q)
            WAIT_LOW: begin
                hlen_d = '0;
                if (!sync_lvl) st_d = IDLE;
            end
            IDLE: begin
                hlen_d = '0;
                if (sync_lvl) begin
                    hlen_d = HLEN_W'(1);
`ifdef CDC_PULSE_GLITCH_FILTER_EN
                    if (MIN_L <= HLEN_W'(1)) begin
                        accept = 1'b1;
                        st_d   = HIGH;
                    end else begin
                        st_d = QUAL;
                    end
`else
                    accept = 1'b1;
                    st_d   = HIGH;
`endif
                end
            end
            QUAL: begin
`ifdef CDC_PULSE_GLITCH_FILTER_EN
                if (!sync_lvl) begin
                    st_d   = IDLE;
                    hlen_d = '0;
                end else begin
                    hlen_d = hlen_inc;
                    if (hlen_inc == MIN_L) begin
                        accept = 1'b1;
                        st_d   = HIGH;
                    end
                end
`else
                st_d   = IDLE;
                hlen_d = '0;
`endif
            end
            HIGH: begin
                if (!sync_lvl) begin
                    st_d   = IDLE;
                    hlen_d = '0;
                end else if (hlen_inc == MAX_L) begin
                    // merged pulses: wait for a clean low before re-arming
                    stuck_set = 1'b1;
                    st_d      = WAIT_LOW;
                    hlen_d    = '0;
                end else begin
                    hlen_d = hlen_inc;
                end
            end
            default: begin
                st_d   = WAIT_LOW;
                hlen_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= WAIT_LOW;
            hlen_q    <= '0;
            evt_pulse <= 1'b0;
            overrun   <= 1'b0;
            stuck_err <= 1'b0;
        end else begin
            st_q      <= st_d;
            hlen_q    <= hlen_d;
            evt_pulse <= accept;
            overrun   <= (cnt_ovf & cnt_full) | (overrun & ~err_clr);
            stuck_err <= stuck_set | (stuck_err & ~err_clr);
        end
    end

    cdc_evt_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .dec   (evt_ready),
        .count (pending),
        .full  (cnt_full),
        .empty (cnt_empty),
        .ovf   (cnt_ovf)
    );

    assign evt_valid = ~cnt_empty;

endmodule

// File: tb/tb_cdc_slow_pulse_recv.sv
// Randomized and directed bench for cdc_slow_pulse_recv.
// Expected values come from a run-length model of the level input.
module tb_cdc_slow_pulse_recv;

    localparam int CNT_W    = 3;
    localparam int MIN_HIGH = 2;
    localparam int MAX_HIGH = 8;
    localparam int MAXP     = (1 << CNT_W) - 1;
`ifdef CDC_PULSE_GLITCH_FILTER_EN
    localparam int MINH = MIN_HIGH;
`else
    localparam int MINH = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sync_lvl = 1'b1;
    logic             err_clr = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_pulse, evt_valid, overrun, stuck_err;
    logic [CNT_W-1:0] pending;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state
    int m_pend, m_run;
    bit m_pulse, m_ovr, m_stuck, m_armed;

    wire [CNT_W+3:0] act = {evt_pulse, evt_valid, pending, overrun, stuck_err};

    cdc_slow_pulse_recv #(
        .CNT_W    (CNT_W),
        .MIN_HIGH (MIN_HIGH),
        .MAX_HIGH (MAX_HIGH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_lvl  (sync_lvl),
        .err_clr   (err_clr),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overrun   (overrun),
        .stuck_err (stuck_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pend  = 0;
        m_run   = 0;
        m_pulse = 0;
        m_ovr   = 0;
        m_stuck = 0;
        m_armed = 0;
    endfunction

    function automatic void model_edge(bit s, bit r, bit c);
        bit acc, stk, pop, ovf;
        acc = m_armed && s && (m_run + 1 == MINH);
        stk = m_armed && s && (m_run + 1 == MAX_HIGH);
        pop = r && (m_pend > 0);
        ovf = 0;
        if (acc && !pop) begin
            if (m_pend == MAXP) ovf = 1;
            else m_pend++;
        end else if (pop && !acc) begin
            m_pend--;
        end
        m_pulse = acc;
        m_ovr   = ovf || (m_ovr && !c);
        m_stuck = stk || (m_stuck && !c);
        if (!s) begin
            m_armed = 1;
            m_run   = 0;
        end else if (m_armed) begin
            if (stk) begin
                m_armed = 0;
                m_run   = 0;
            end else begin
                m_run++;
            end
        end
    endfunction

    function automatic logic [CNT_W+3:0] exp_vec();
        return {m_pulse, m_pend != 0, CNT_W'(m_pend), m_ovr, m_stuck};
    endfunction

    task automatic step(input bit s, input bit r, input bit c);
        @(negedge clk);
        sync_lvl  = s;
        evt_ready = r;
        err_clr   = c;
        @(posedge clk);
        model_edge(s, r, c);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int np = 0;
        model_reset();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_vals act=%b exp=0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            if (evt_pulse) np++;
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL reset_high cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
            end
        end
        step(0, 0, 0);
        checks++;
        if (np != 0 || pending !== '0 || stuck_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_evt pulses=%0d pending=%0d exp 0", np, pending);
        end
    endtask

    task automatic test_back_to_back();
        int np = 0;
        int exp_p [4] = '{2, 1, 0, 0};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                step(i < 3, 0, 0);
                if (evt_pulse) np++;
                checks++;
                if (act !== exp_vec()) begin
                    errors++;
                    $display("FAIL b2b cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
                end
            end
        end
        checks++;
        if (np != 3 || pending !== CNT_W'(3) || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count pulses=%0d pending=%0d exp 3", np, pending);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0);
            checks++;
            if (pending !== CNT_W'(exp_p[i]) || evt_valid !== (exp_p[i] != 0)) begin
                errors++;
                $display("FAIL b2b_pop i=%0d pending=%0d exp=%0d", i, pending, exp_p[i]);
            end
        end
    endtask

    task automatic test_glitch_filter();
        int np = 0;
        int first_pulse = -1;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            step(pat[i], 0, 0);
            if (evt_pulse) begin
                np++;
                if (first_pulse < 0) first_pulse = i;
            end
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL glitch cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
            end
        end
        checks++;
`ifdef CDC_PULSE_GLITCH_FILTER_EN
        if (np != 1 || first_pulse != 4) begin
`else
        if (np != 2 || first_pulse != 0) begin
`endif
            errors++;
            $display("FAIL glitch_count pulses=%0d first=%0d", np, first_pulse);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < MAXP + 1; k++) begin
            for (int j = 0; j <= MINH; j++) begin
                step(j < MINH, 0, 0);
                checks++;
                if (act !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
                end
            end
        end
        checks++;
        if (pending !== CNT_W'(MAXP) || overrun !== 1'b1) begin
            errors++;
            $display("FAIL sat_full pending=%0d ovr=%b exp %0d/1", pending, overrun, MAXP);
        end
        step(0, 0, 1);
        for (int j = 0; j < MINH; j++) step(1, j == MINH - 1, 0);
        checks++;
        if (pending !== CNT_W'(MAXP) || overrun !== 1'b0 || act !== exp_vec()) begin
            errors++;
            $display("FAIL sat_pop pending=%0d ovr=%b exp %0d/0", pending, overrun, MAXP);
        end
        for (int i = 0; i < MAXP + 1; i++) begin
            step(0, 1, 0);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL drain cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
            end
        end
    endtask

    task automatic test_stuck();
        int np = 0;
        step(0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 0);
            if (evt_pulse) np++;
            checks++;
            if (stuck_err !== (i >= MAX_HIGH) || act !== exp_vec()) begin
                errors++;
                $display("FAIL stuck i=%0d act=%b exp=%b", i, act, exp_vec());
            end
        end
        checks++;
        if (np != 1) begin
            errors++;
            $display("FAIL stuck_pulses got=%0d exp=1", np);
        end
        step(0, 1, 1);
        checks++;
        if (stuck_err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clr got=%b exp=0", stuck_err);
        end
        for (int i = 1; i <= MAX_HIGH; i++) step(1, 1, i == MAX_HIGH);
        checks++;
        if (stuck_err !== 1'b1 || act !== exp_vec()) begin
            errors++;
            $display("FAIL stuck_set_wins got=%b exp=1", stuck_err);
        end
        step(0, 1, 1);
    endtask

    task automatic test_async_reset();
        int np = 0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j <= MINH; j++) step(j < MINH, 0, 0);
        end
        checks++;
        if (pending !== CNT_W'(2) || act !== exp_vec()) begin
            errors++;
            $display("FAIL arst_pre pending=%0d exp=2", pending);
        end
        step(1, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL arst_async act=%b exp=0", act);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            if (evt_pulse) np++;
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL arst_post cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
            end
        end
        checks++;
        if (np != 0) begin
            errors++;
            $display("FAIL arst_no_evt pulses=%0d exp=0", np);
        end
        for (int j = 0; j <= MINH + 1; j++) begin
            step(j > 0 && j <= MINH, 0, 0);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL arst_rearm cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit lvl = 0;
        int rem = 1;
        for (int i = 0; i < 3000; i++) begin
            if (rem == 0) begin
                lvl = ~lvl;
                rem = lvl ? $urandom_range(1, 11) : $urandom_range(1, 3);
            end
            step(lvl, ($urandom % 3) == 0, ($urandom % 16) == 0);
            rem--;
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_back_to_back();
        test_glitch_filter();
        test_saturate();
        test_stuck();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdc_slow_pulse_recv.md
# cdc_slow_pulse_recv

Slow-domain receiver for fast-to-slow pulse crossings. It consumes the synchronized, stretched level produced by the fast-to-slow pulse stretcher/synchronizer and turns each accepted high period into exactly one single-cycle event. Events are queued in a saturating pending counter and drained through a valid/ready handshake. Stretch-width faults are flagged: high periods that are too long (merged pulses), and with the filter compiled in, high periods that are too short (glitches).

## Interface
Parameters:
- CNT_W, 4: width of the pending-event counter; capacity is 2^CNT_W-1 events.
- MIN_HIGH, 2: consecutive high samples required to accept an event (filter build only); legal range 1..MAX_HIGH-1.
- MAX_HIGH, 8: consecutive high samples at which the level is declared stuck; legal range 2..255.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: slow-domain clock.
- rst_n, input, 1: asynchronous active-low reset.
- sync_lvl, input, 1: already-synchronized stretched level. No further synchronizer is added.
- err_clr, input, 1: single-cycle clear of the sticky flags.
- evt_pulse, output, 1: one-cycle strobe per accepted event.
- evt_valid, output, 1: high while pending != 0.
- evt_ready, input, 1: consumer accepts one event when evt_valid && evt_ready.
- pending, output, CNT_W: number of queued events.
- overrun, output, 1: sticky; an event arrived while the counter was full with no pop.
- stuck_err, output, 1: sticky; the level was high for MAX_HIGH samples.

## Operation
- FSM states:
  - WAIT_LOW (reset state): go to IDLE when sync_lvl=0. A level that is already high at reset release never produces an event.
  - IDLE: on sync_lvl=1, go to QUAL (filter build) or accept the event and go to HIGH (no-filter build). The high-length counter is loaded with 1.
  - QUAL: on sync_lvl=0, go to IDLE with no event. On sync_lvl=1, increment the high-length counter; when the count reaches MIN_HIGH, accept the event and go to HIGH.
  - HIGH: on sync_lvl=0, go to IDLE. On sync_lvl=1, increment; when the count reaches MAX_HIGH, set stuck_err and go to WAIT_LOW.
- High-length counter: 8 bits, saturating, cleared in IDLE and WAIT_LOW.
- Accepting an event:
  - evt_pulse is asserted for exactly one cycle.
  - pending is incremented, unless a pop happens in the same cycle.
- Pending counter update rules:
  - Accept and pop in the same cycle: pending unchanged.
  - Pop only: decrement.
  - Accept while full with no pop: pending stays at max and overrun is set.
  - Accept while full with a pop: pending unchanged, no overrun.
  - evt_ready while pending=0: no effect; the counter never underflows.
- Sticky flags: err_clr clears overrun and stuck_err. A set condition in the same cycle as err_clr wins, so the flag stays 1.

## Timing
- All outputs are registered. Reset values: evt_pulse=0, evt_valid=0, pending=0, overrun=0, stuck_err=0, FSM=WAIT_LOW.
- No-filter build:
  - The first high sample is at edge n; evt_pulse is high in cycle n+1.
  - pending and evt_valid update at edge n, so both are visible in cycle n+1.
- Filter build: latency from the first high sample to evt_pulse is MIN_HIGH cycles.
- A pop at edge m is reflected in pending and evt_valid in cycle m+1.
- stuck_err rises one cycle after the MAX_HIGH-th consecutive high sample.
- Minimum legal input pattern: low for at least 1 cycle between highs. A single-cycle low between highs still re-arms the FSM (HIGH→IDLE→next event).
- Reset assertion mid-operation clears pending, so queued events are lost by design. After release, a new event requires a low-then-high sequence.

## Configuration
- CDC_PULSE_GLITCH_FILTER_EN defined:
  - The QUAL state and the MIN_HIGH parameter are active.
  - High periods shorter than MIN_HIGH samples are discarded silently.
- Not defined:
  - QUAL is absent and IDLE goes directly to HIGH.
  - MIN_HIGH is ignored.
  - Every high period of length 1..MAX_HIGH-1 yields one event.

## Structure
- Shared package cdc_pkg holds:
  - the FSM state enum (WAIT_LOW, IDLE, QUAL, HIGH);
  - the high-length counter width constant (8);
  - default parameter constants.
- One sub-module, cdc_evt_cnt, is natural here. It is a CNT_W saturating up/down counter with inc, dec, full and empty outputs, and a full-on-inc overrun strobe.

## Test plan
- Reset release with sync_lvl=1 held for 5 cycles, then low → no evt_pulse, pending=0, stuck_err=0.
- No-filter build, three 3-cycle highs separated by 2-cycle lows, evt_ready=0 → three evt_pulse strobes, pending=3, evt_valid=1. Then evt_ready=1 for 4 cycles → pending 2,1,0,0, evt_valid falls after the third pop.
- Filter build, MIN_HIGH=2, a 1-cycle high then a 2-cycle high → only the second produces evt_pulse, exactly 2 cycles after its first high sample.
- CNT_W=2, four events with evt_ready=0 → pending saturates at 3 and overrun=1. A fifth event coinciding with a pop → pending stays 3. err_clr → overrun=0.
- MAX_HIGH=8, sync_lvl high for 12 cycles → exactly one evt_pulse and stuck_err=1 after the 8th sample. No new event until low then high. err_clr asserted in the same cycle as a new stuck detection → stuck_err remains 1.
- pending=2, rst_n asserted mid-high → all outputs 0 immediately (asynchronously). After release, the FSM is in WAIT_LOW and the ongoing high produces no event.
